// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM rotor stepper (rotor geometry, FSM states, position packing).
// Latency: n/a (package only).
// Backpressure: n/a.
package mem_pkg;

   localparam int         NUM_ROTORS = 3;
   localparam int         ROTOR_SIZE = 26;
   localparam int         POS_W      = 5;
   localparam logic [4:0] POS_SIZE   = 5'(ROTOR_SIZE);
   localparam logic [4:0] POS_LAST   = 5'(ROTOR_SIZE - 1);
   localparam logic [4:0] NOTCH      = 5'd16;
   localparam logic [8:1] ASCII_A    = 8'h41;

   typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

   // Rotor position word: {pos2[14:10], pos1[9:5], pos0[4:0]}
   typedef struct packed {
      logic [POS_W-1:0] pos2;
      logic [POS_W-1:0] pos1;
      logic [POS_W-1:0] pos0;
   } pos_t;

   // Reduce a value in 0..77 modulo 26 with two conditional subtracts.
   function automatic logic [4:0] mod26_small(input logic [6:0] s);
      logic [4:0] r;
      if (s >= 7'd52)      r = 5'(s - 7'd52);
      else if (s >= 7'd26) r = 5'(s - 7'd26);
      else                 r = 5'(s);
      return r;
   endfunction

endpackage

// File: rtl/mem_rotor_stepper_if.sv
// Character stream in / {char, setting} pair out handshake bundle for the rotor stepper.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both sides; slave = stepper, master = upstream/MEM side.
interface mem_rotor_stepper_if;
   logic       s_valid;
   logic       s_ready;
   logic [8:1] s_char;
   logic       m_valid;
   logic       m_ready;
   logic [8:1] m_char;
   logic [2:1] m_setting;

   modport slave  (input  s_valid, s_char, m_ready,
                   output s_ready, m_valid, m_char, m_setting);
   modport master (output s_valid, s_char, m_ready,
                   input  s_ready, m_valid, m_char, m_setting);
endinterface

// File: rtl/mem_rotor_cell.sv
// One rotor: mod-26 position counter with load (reduced mod 26), step input and at-notch flag.
// Latency: position updates on the clock after load_i/step_i; pos_nxt_o shows that value now.
// Backpressure: none; load_i has priority over step_i.
// Ports: clk, rst, load_i, load_val_i[4:0], step_i -> pos_o[4:0], pos_nxt_o[4:0], at_notch_o.
module mem_rotor_cell
   import mem_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       load_i,
   input  logic [4:0] load_val_i,
   input  logic       step_i,
   output logic [4:0] pos_o,
   output logic [4:0] pos_nxt_o,
   output logic       at_notch_o
);

   logic [4:0] pos_q, pos_d;

   always_comb begin
      pos_d = pos_q;
      if (load_i) begin
         // 5-bit field can hold 26..31; one subtract brings it into range
         pos_d = (load_val_i >= POS_SIZE) ? load_val_i - POS_SIZE : load_val_i;
      end else if (step_i) begin
         pos_d = (pos_q == POS_LAST) ? 5'd0 : pos_q + 5'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) pos_q <= 5'd0;
      else     pos_q <= pos_d;
   end

   assign pos_o      = pos_q;
   assign pos_nxt_o  = pos_d;
   assign at_notch_o = (pos_q == NOTCH);

endmodule

// File: rtl/mem_rotor_stepper.sv
// Folds letters to uppercase, steps a 3-rotor odometer per letter and pre-shifts by the rotor sum.
// Latency: 1 clk from accept to registered {m_char, m_setting}; 1 char/clk when m_ready stays high.
// Backpressure: s_ready drops while a pair is stalled, while loading, and before the first load.
// Ports: clk, rst, load_en/load_pos/load_set, bus (mem_rotor_stepper_if.slave), pos, char_count.
// Build option: define DOUBLE_STEP_EN for the Enigma double-step anomaly on the middle rotor.
module mem_rotor_stepper
   import mem_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       load_en,
   input  logic [14:0]                load_pos,
   input  logic [1:0]                 load_set,
   mem_rotor_stepper_if.slave         bus,
   output logic [14:0]                pos,
   output logic [15:0]                char_count
);

   state_t     state_q;
   logic       m_valid_q;
   logic [8:1] m_char_q;
   logic [1:0] m_setting_q;
   logic [1:0] set_q;        // setting applied to the next accepted character
   logic [15:0] cnt_q;

   pos_t       load_p;
   logic [4:0] cur0, cur1, cur2;
   logic [4:0] nxt0, nxt1, nxt2;
   logic       notch0, notch1, notch2;
   logic       carry1, carry2;

   logic       s_ready;
   logic       accept;
   logic       is_letter;
   logic       step_letter;
   logic [8:1] folded;
   logic [8:1] rel;
   logic [4:0] off;
   logic [4:0] shift;
   logic [8:1] shifted;

   assign load_p = pos_t'(load_pos);

   assign s_ready = (state_q == RUN) && !load_en && (!m_valid_q || bus.m_ready);
   assign accept  = bus.s_valid && s_ready;

   assign is_letter = ((bus.s_char >= 8'h41) && (bus.s_char <= 8'h5A)) ||
                      ((bus.s_char >= 8'h61) && (bus.s_char <= 8'h7A));
   // Clearing ASCII bit 6 (value 0x20) maps 'a'..'z' onto 'A'..'Z'
   assign folded      = {bus.s_char[8:7], 1'b0, bus.s_char[5:1]};
   assign step_letter = accept && is_letter;

`ifdef DOUBLE_STEP_EN
   // Middle rotor sitting on its notch drags itself and the left rotor along
   assign carry1 = notch0 | notch1;
   assign carry2 = notch1;
`else
   assign carry1 = notch0;
   assign carry2 = notch0 & notch1;
`endif

   mem_rotor_cell u_rot0 (
      .clk(clk), .rst(rst), .load_i(load_en), .load_val_i(load_p.pos0),
      .step_i(step_letter), .pos_o(cur0), .pos_nxt_o(nxt0), .at_notch_o(notch0)
   );
   mem_rotor_cell u_rot1 (
      .clk(clk), .rst(rst), .load_i(load_en), .load_val_i(load_p.pos1),
      .step_i(step_letter && carry1), .pos_o(cur1), .pos_nxt_o(nxt1), .at_notch_o(notch1)
   );
   mem_rotor_cell u_rot2 (
      .clk(clk), .rst(rst), .load_i(load_en), .load_val_i(load_p.pos2),
      .step_i(step_letter && carry2), .pos_o(cur2), .pos_nxt_o(nxt2), .at_notch_o(notch2)
   );

   // Offset uses the post-step positions (sum <= 75)
   assign off     = mod26_small({2'b00, nxt0} + {2'b00, nxt1} + {2'b00, nxt2});
   assign rel     = folded - ASCII_A;
   assign shift   = mod26_small({2'b00, rel[5:1]} + {2'b00, off});
   assign shifted = ASCII_A + {3'b000, shift};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         m_valid_q   <= 1'b0;
         m_char_q    <= 8'h00;
         m_setting_q <= 2'b00;
         set_q       <= 2'b00;
         cnt_q       <= 16'd0;
      end else begin
         case (state_q)
            IDLE:    if (load_en) state_q <= RUN;
            RUN:     if (m_valid_q && !bus.m_ready) state_q <= HOLD;
            HOLD:    if (bus.m_ready) state_q <= RUN;
            default: state_q <= IDLE;
         endcase

         if (accept) begin
            m_valid_q   <= 1'b1;
            m_char_q    <= is_letter ? shifted : bus.s_char;
            m_setting_q <= set_q;
         end else if (bus.m_ready) begin
            m_valid_q   <= 1'b0;
         end

         if (load_en) begin
            set_q <= load_set;
            cnt_q <= 16'd0;
            // A stalled pair keeps its setting; the new one rides on the next char
            if (!m_valid_q || bus.m_ready) m_setting_q <= load_set;
         end else if (step_letter && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'd1;
         end
      end
   end

   assign bus.s_ready   = s_ready;
   assign bus.m_valid   = m_valid_q;
   assign bus.m_char    = m_char_q;
   assign bus.m_setting = m_setting_q;
   assign pos           = {cur2, cur1, cur0};
   assign char_count    = cnt_q;

   logic unused_ok;
   assign unused_ok = notch2;

endmodule

// File: tb/tb_mem_rotor_stepper.sv
module tb_mem_rotor_stepper;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load_en = 1'b0;
   logic [14:0] load_pos = '0;
   logic [1:0]  load_set = '0;
   logic [14:0] pos;
   logic [15:0] char_count;

   mem_rotor_stepper_if bus();

   mem_rotor_stepper dut (
      .clk(clk), .rst(rst), .load_en(load_en), .load_pos(load_pos), .load_set(load_set),
      .bus(bus), .pos(pos), .char_count(char_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [14:0] pk(input int p2, input int p1, input int p0);
      logic [4:0] a, b, c;
      a = p2[4:0]; b = p1[4:0]; c = p0[4:0];
      return {a, b, c};
   endfunction

   typedef struct {
      logic        ld;
      logic [14:0] lpos;
      logic [1:0]  lset;
      logic [7:0]  c;
      logic [14:0] epos;
      logic [7:0]  ech;
      logic [15:0] ecnt;
      logic [1:0]  eset;
   } vec_t;

   vec_t tbl[13];

   // reference model state
   int         mp[3];
   int         mcnt;
   bit         mrun, mmv, mstall;
   logic [7:0] mchar;
   logic [1:0] mset, mset_ld;
`ifdef DOUBLE_STEP_EN
   localparam bit DS = 1'b1;
`else
   localparam bit DS = 1'b0;
`endif

   initial begin
      tbl[0]  = '{1'b1, pk(0,0,0),    2'd1, 8'h41, pk(0,0,1),    8'h42, 16'd1, 2'd1};
      tbl[1]  = '{1'b1, pk(0,0,16),   2'd2, 8'h41, pk(0,1,17),   8'h53, 16'd1, 2'd2};
      tbl[2]  = '{1'b0, 15'd0,        2'd0, 8'h61, pk(0,1,18),   8'h54, 16'd2, 2'd2};
      tbl[3]  = '{1'b1, pk(25,25,25), 2'd3, 8'h41, pk(25,25,0),  8'h59, 16'd1, 2'd3};
      tbl[4]  = '{1'b0, 15'd0,        2'd0, 8'h20, pk(25,25,0),  8'h20, 16'd1, 2'd3};
`ifdef DOUBLE_STEP_EN
      tbl[5]  = '{1'b1, pk(3,16,5),   2'd0, 8'h41, pk(4,17,6),   8'h42, 16'd1, 2'd0};
`else
      tbl[5]  = '{1'b1, pk(3,16,5),   2'd0, 8'h41, pk(3,16,6),   8'h5A, 16'd1, 2'd0};
`endif
      tbl[6]  = '{1'b1, pk(0,0,0),    2'd1, 8'h7A, pk(0,0,1),    8'h41, 16'd1, 2'd1};
      tbl[7]  = '{1'b0, 15'd0,        2'd0, 8'h40, pk(0,0,1),    8'h40, 16'd1, 2'd1};
      tbl[8]  = '{1'b0, 15'd0,        2'd0, 8'h5B, pk(0,0,1),    8'h5B, 16'd1, 2'd1};
      tbl[9]  = '{1'b0, 15'd0,        2'd0, 8'h60, pk(0,0,1),    8'h60, 16'd1, 2'd1};
      tbl[10] = '{1'b0, 15'd0,        2'd0, 8'h7B, pk(0,0,1),    8'h7B, 16'd1, 2'd1};
      tbl[11] = '{1'b1, pk(0,16,16),  2'd2, 8'h41, pk(1,17,17),  8'h4A, 16'd1, 2'd2};
      tbl[12] = '{1'b1, pk(31,26,30), 2'd0, 8'h41, pk(5,0,5),    8'h4B, 16'd1, 2'd0};

      bus.s_valid = 1'b0;
      bus.s_char  = 8'h00;
      bus.m_ready = 1'b0;

      // reset state
      #12;
      chk("rst_pos", pos, 0);
      chk("rst_cnt", char_count, 0);
      chk("rst_mvalid", bus.m_valid, 0);
      chk("rst_mchar", bus.m_char, 0);
      chk("rst_mset", bus.m_setting, 0);
      @(negedge clk);
      rst = 1'b0;
      // IDLE refuses characters until positions are loaded
      bus.s_valid = 1'b1; bus.s_char = 8'h41; bus.m_ready = 1'b1;
      #1 chk("idle_sready", bus.s_ready, 0);
      @(posedge clk); #1;
      chk("idle_no_accept", bus.m_valid, 0);
      bus.s_valid = 1'b0;

      // directed vector table
      for (int i = 0; i < 13; i++) begin
         if (tbl[i].ld) begin
            @(negedge clk);
            load_en = 1'b1; load_pos = tbl[i].lpos; load_set = tbl[i].lset;
            @(posedge clk); #1;
            load_en = 1'b0;
         end
         bus.s_valid = 1'b1; bus.s_char = tbl[i].c; bus.m_ready = 1'b1;
         @(negedge clk);
         chk($sformatf("v%0d_sready", i), bus.s_ready, 1);
         @(posedge clk); #1;
         bus.s_valid = 1'b0;
         chk($sformatf("v%0d_mvalid", i), bus.m_valid, 1);
         chk($sformatf("v%0d_mchar", i), bus.m_char, tbl[i].ech);
         chk($sformatf("v%0d_pos", i), pos, tbl[i].epos);
         chk($sformatf("v%0d_cnt", i), char_count, tbl[i].ecnt);
         chk($sformatf("v%0d_mset", i), bus.m_setting, tbl[i].eset);
      end

      // backpressure: pair holds for 5 clks, next char waits, then drains
      @(negedge clk);
      load_en = 1'b1; load_pos = pk(0,0,0); load_set = 2'd1;
      @(posedge clk); #1;
      load_en = 1'b0;
      bus.s_valid = 1'b1; bus.s_char = 8'h41; bus.m_ready = 1'b0;
      @(posedge clk); #1;
      bus.s_char = 8'h42;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_mvalid", bus.m_valid, 1);
         chk("bp_mchar", bus.m_char, 8'h42);
         chk("bp_sready", bus.s_ready, 0);
      end
      @(negedge clk);
      bus.m_ready = 1'b1;
      #1 chk("bp_release_sready", bus.s_ready, 0);
      @(posedge clk); #1;
      chk("bp_drained", bus.m_valid, 0);
      @(negedge clk);
      chk("bp_next_sready", bus.s_ready, 1);
      @(posedge clk); #1;
      bus.s_valid = 1'b0;
      chk("bp_next_mvalid", bus.m_valid, 1);
      chk("bp_next_mchar", bus.m_char, 8'h44);
      chk("bp_next_pos", pos, pk(0,0,2));
      chk("bp_next_cnt", char_count, 2);

      // load wins over a simultaneous character
      @(negedge clk);
      load_en = 1'b1; load_pos = pk(2,3,4); load_set = 2'd2;
      bus.s_valid = 1'b1; bus.s_char = 8'h41;
      #1 chk("ld_sv_sready", bus.s_ready, 0);
      @(posedge clk); #1;
      load_en = 1'b0; bus.s_valid = 1'b0;
      chk("ld_sv_mvalid", bus.m_valid, 0);
      chk("ld_sv_pos", pos, pk(2,3,4));
      chk("ld_sv_cnt", char_count, 0);
      chk("ld_sv_mset", bus.m_setting, 2);

      // asynchronous reset while a pair is held
      bus.s_valid = 1'b1; bus.s_char = 8'h41; bus.m_ready = 1'b0;
      @(posedge clk); #1;
      bus.s_valid = 1'b0;
      chk("pre_rst_mvalid", bus.m_valid, 1);
      rst = 1'b1;
      #1;
      chk("arst_mvalid", bus.m_valid, 0);
      chk("arst_mchar", bus.m_char, 0);
      chk("arst_mset", bus.m_setting, 0);
      chk("arst_pos", pos, 0);
      chk("arst_cnt", char_count, 0);
      chk("arst_sready", bus.s_ready, 0);
      @(negedge clk);
      rst = 1'b0;

      // randomized run against the reference model
      for (int k = 0; k < 3; k++) mp[k] = 0;
      mcnt = 0; mrun = 0; mmv = 0; mstall = 0; mchar = 8'h00; mset = 2'd0; mset_ld = 2'd0;
      for (int it = 0; it < 3000; it++) begin
         bit         ld, acc, exp_sr, old_mv;
         logic [7:0] c;
         @(negedge clk);
         chk("rnd_pos", pos, pk(mp[2], mp[1], mp[0]));
         chk("rnd_cnt", char_count, mcnt);
         chk("rnd_mvalid", bus.m_valid, mmv);
         if (mmv) chk("rnd_mchar", bus.m_char, mchar);
         chk("rnd_mset", bus.m_setting, mset);

         ld = ($urandom_range(0, 19) == 0);
         load_en = ld;
         load_pos = 15'($urandom);
         load_set = 2'($urandom);
         bus.s_valid = ($urandom_range(0, 2) != 0);
         case ($urandom_range(0, 2))
            0:       c = 8'(8'h41 + $urandom_range(0, 25));
            1:       c = 8'(8'h61 + $urandom_range(0, 25));
            default: c = 8'($urandom_range(32, 126));
         endcase
         bus.s_char = c;
         bus.m_ready = ($urandom_range(0, 3) != 0);
         exp_sr = mrun && !ld && !mstall && (!mmv || bus.m_ready);
         #1 chk("rnd_sready", bus.s_ready, exp_sr);

         acc = bus.s_valid && exp_sr;
         old_mv = mmv;
         if (old_mv && bus.m_ready) begin mmv = 0; mstall = 0; end
         else if (old_mv) mstall = 1;
         if (ld) begin
            mp[0] = int'(load_pos[4:0]) % 26;
            mp[1] = int'(load_pos[9:5]) % 26;
            mp[2] = int'(load_pos[14:10]) % 26;
            mcnt = 0; mrun = 1; mset_ld = load_set;
            if (!old_mv || bus.m_ready) mset = load_set;
         end
         if (acc) begin
            int uc;
            uc = (c >= 8'h61 && c <= 8'h7A) ? int'(c) - 32 : int'(c);
            if (uc >= 65 && uc <= 90) begin
               int o0, o1, o2, off;
               bit c1, c2;
               o0 = mp[0]; o1 = mp[1]; o2 = mp[2];
               c1 = (o0 == 16) || (DS && o1 == 16);
               c2 = (o0 == 16 && o1 == 16) || (DS && o1 == 16);
               mp[0] = (o0 + 1) % 26;
               if (c1) mp[1] = (o1 + 1) % 26;
               if (c2) mp[2] = (o2 + 1) % 26;
               off = (mp[0] + mp[1] + mp[2]) % 26;
               mchar = 8'(65 + (uc - 65 + off) % 26);
               if (mcnt < 65535) mcnt++;
            end else begin
               mchar = c;
            end
            mmv = 1; mstall = 0; mset = mset_ld;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
